fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_branch_cmp.sv | 35 +++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// branch comparison codes and reset defaults.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BT_EQ  = 3'b000,
    BT_NE  = 3'b001,
    BT_GT  = 3'b010,
    BT_LT  = 3'b011,
    BT_GE  = 3'b100,
    BT_LE  = 3'b101,
    BT_GTU = 3'b110,
    BT_LEU = 3'b111
  } branch_type_e;

  localparam logic [31:0] DEFAULT_RESET_PC      = 32'h0000_0000;
  localparam int          DEFAULT_FETCH_TIMEOUT = 16;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_branch_cmp.sv
// Combinational branch condition evaluation: compares cmp_a against cmp_b
// according to the branch type code and reports whether the branch is taken.
module fetch_unit_branch_cmp
  import fetch_unit_pkg::*;
(
  input  logic [31:0] cmp_a_i,
  input  logic [31:0] cmp_b_i,
  input  logic [2:0]  branch_type_i,
  output logic        taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (cmp_a_i == cmp_b_i);
  assign lt_s = ($signed(cmp_a_i) < $signed(cmp_b_i));
  assign lt_u = (cmp_a_i < cmp_b_i);

  always_comb begin
    taken_o = 1'b0;
    case (branch_type_e'(branch_type_i))
      BT_EQ:   taken_o = eq;
      BT_NE:   taken_o = !eq;
      BT_GT:   taken_o = !lt_s && !eq;
      BT_LT:   taken_o = lt_s;
      BT_GE:   taken_o = !lt_s;
      BT_LE:   taken_o = lt_s || eq;
      BT_GTU:  taken_o = !lt_u && !eq;
      BT_LEU:  taken_o = lt_u || eq;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds and
// decodes the current instruction, and computes the next PC on acknowledge.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int          FETCH_TIMEOUT = DEFAULT_FETCH_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ack_i,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_field_o,
  output logic [4:0]  rt_field_o,
  output logic [4:0]  rd_field_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [31:0] imm_sext_o,
  output logic [31:0] pc_out_o,
  output logic [31:0] pc_plus4_o,
  input  logic        branch_i,
  input  logic [2:0]  branch_type_i,
  input  logic        jump_i,
  input  logic        jump_reg_i,
  input  logic [31:0] cmp_a_i,
  input  logic [31:0] cmp_b_i,
  input  logic [31:0] jr_target_i,
  output logic        misaligned_o,
  output logic        fetch_err_o
);

  localparam int               CNT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             fetch_err_q, fetch_err_d;
  logic             misaligned_q, misaligned_d;

  logic [31:0]      pc_plus4;
  logic [31:0]      imm_sext;
  logic [31:0]      next_pc;
  logic             cmp_taken;

  assign pc_plus4 = pc_q + 32'd4;
  assign imm_sext = sext16(instr_q[15:0]);

  fetch_unit_branch_cmp u_branch_cmp (
    .cmp_a_i       (cmp_a_i),
    .cmp_b_i       (cmp_b_i),
    .branch_type_i (branch_type_i),
    .taken_o       (cmp_taken)
  );

  // Redirect priority: register jump, then absolute jump, then taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg_i) begin
      next_pc = {jr_target_i[31:2], 2'b00};
    end else if (jump_i) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch_i && cmp_taken) begin
      next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    tmo_cnt_d    = tmo_cnt_q;
    fetch_err_d  = fetch_err_q;
    misaligned_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_FETCH;
        tmo_cnt_d = '0;
      end
      ST_FETCH: begin
        if (imem_ready_i) begin
          instr_d   = imem_rdata_i;
          state_d   = ST_HOLD;
          tmo_cnt_d = '0;
        end else begin
          // Counter saturates; the error flag stays set while retrying.
          if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          if (tmo_cnt_q >= TMO_LAST) fetch_err_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (instr_ack_i) begin
          pc_d         = next_pc;
          state_d      = ST_FETCH;
          misaligned_d = jump_reg_i && (jr_target_i[1:0] != 2'b00);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      tmo_cnt_q    <= '0;
      fetch_err_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      fetch_err_q  <= fetch_err_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Request and valid come straight from state so reset drops them at once.
  assign imem_req_o    = (state_q == ST_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == ST_HOLD);

  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[31:26];
  assign rs_field_o = instr_q[25:21];
  assign rt_field_o = instr_q[20:16];
  assign rd_field_o = instr_q[15:11];
  assign shamt_o    = instr_q[10:6];
  assign funct_o    = instr_q[5:0];
  assign imm_sext_o = imm_sext;
  assign pc_out_o   = pc_q;
  assign pc_plus4_o = pc_plus4;

  assign misaligned_o = misaligned_q;
  assign fetch_err_o  = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level reference model checked
// every cycle, plus literal next-address expectations for each instruction.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          FT  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready, instr_valid, instr_ack;
  logic [31:0] imem_addr, imem_rdata, instr, imm_sext, pc_out, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_field, rt_field, rd_field, shamt;
  logic        branch, jump, jump_reg, misaligned, fetch_err;
  logic [2:0]  branch_type;
  logic [31:0] cmp_a, cmp_b, jr_target;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FETCH_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_ack_i(instr_ack),
    .instr_o(instr), .opcode_o(opcode), .rs_field_o(rs_field), .rt_field_o(rt_field),
    .rd_field_o(rd_field), .shamt_o(shamt), .funct_o(funct), .imm_sext_o(imm_sext),
    .pc_out_o(pc_out), .pc_plus4_o(pc_plus4),
    .branch_i(branch), .branch_type_i(branch_type), .jump_i(jump), .jump_reg_i(jump_reg),
    .cmp_a_i(cmp_a), .cmp_b_i(cmp_b), .jr_target_i(jr_target),
    .misaligned_o(misaligned), .fetch_err_o(fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_taken(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (bt)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa > sb;
      3'd3:    return sa < sb;
      3'd4:    return sa >= sb;
      3'd5:    return sa <= sb;
      3'd6:    return a > b;
      default: return a <= b;
    endcase
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic br, input logic [2:0] bt,
                                           input logic j, input logic jr,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] jt);
    logic [31:0]        p4;
    logic signed [31:0] off;
    p4  = pc + 32'd4;
    off = $signed(ins[15:0]);
    if (jr) return jt & ~32'h3;
    if (j) return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    if (br && ref_taken(bt, a, b)) return p4 + 32'(off * 4);
    return p4;
  endfunction

  // m_phase: 0 waiting to start, 1 fetching, 2 holding an instruction
  int          m_phase;
  int          m_cnt;
  logic [31:0] m_pc, m_instr;
  bit          m_err, m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_pc    <= RPC;
      m_instr <= '0;
      m_err   <= 1'b0;
      m_mis   <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      case (m_phase)
        0: begin
          m_phase <= 1;
          m_cnt   <= 0;
        end
        1: begin
          if (imem_ready) begin
            m_instr <= imem_rdata;
            m_phase <= 2;
            m_cnt   <= 0;
          end else begin
            if (m_cnt < FT) m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= FT) m_err <= 1'b1;
          end
        end
        default: begin
          if (instr_ack) begin
            m_pc    <= ref_next(m_pc, m_instr, branch, branch_type, jump, jump_reg,
                                cmp_a, cmp_b, jr_target);
            m_mis   <= jump_reg && (jr_target[1:0] != 2'b00);
            m_phase <= 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_phase == 1});
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == 2});
      chk("instr", instr, m_instr);
      chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
      chk("rs", {27'b0, rs_field}, {27'b0, m_instr[25:21]});
      chk("rt", {27'b0, rt_field}, {27'b0, m_instr[20:16]});
      chk("rd", {27'b0, rd_field}, {27'b0, m_instr[15:11]});
      chk("shamt", {27'b0, shamt}, {27'b0, m_instr[10:6]});
      chk("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
      chk("imm_sext", imm_sext, {{16{m_instr[15]}}, m_instr[15:0]});
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    branch = 1'b0; branch_type = 3'd0; jump = 1'b0; jump_reg = 1'b0;
    cmp_a = '0; cmp_b = '0; jr_target = '0;
  endtask

  // Fetch one word, hold it a cycle with noise on ignored inputs, then ack
  // with the given redirect and check the resulting fetch address.
  task automatic issue(input string tag, input logic [31:0] word,
                       input logic br, input logic [2:0] bt, input logic j, input logic jr,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] jt,
                       input logic [31:0] exp_addr, input logic exp_mis);
    int n;
    imem_ready = 1'b1;
    imem_rdata = word;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " accept"}, {31'b0, instr_valid}, 32'd1);
    imem_rdata = 32'hDEAD_BEEF;
    branch = 1'b1; jump = 1'b1; jump_reg = 1'b1; jr_target = 32'h1234_5679;
    tick();
    chk({tag, " held_instr"}, instr, word);
    branch = br; branch_type = bt; jump = j; jump_reg = jr;
    cmp_a = a; cmp_b = b; jr_target = jt;
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    imem_ready = 1'b0;
    clear_redirect();
    chk({tag, " next_addr"}, imem_addr, exp_addr);
    chk({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, exp_mis});
    chk({tag, " valid_drop"}, {31'b0, instr_valid}, 32'd0);
    $display("txn %s: word=%h next_addr=%h", tag, word, imem_addr);
  endtask

  logic [2:0]  tbl_bt  [6] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
  logic        tbl_br  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] tbl_a   [6] = '{32'd3, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd5, 32'd9};
  logic [31:0] tbl_b   [6] = '{32'd3, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd9};
  logic [31:0] tbl_exp [6] = '{32'h104, 32'h110, 32'h11C, 32'h120, 32'h12C, 32'h130};

  initial begin
    imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
    clear_redirect();
    tick(); tick();
    chk("rst imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst imem_addr", imem_addr, RPC);
    chk("rst instr", instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    tick();
    chk("start imem_req", {31'b0, imem_req}, 32'd1);
    chk("start imem_addr", imem_addr, 32'h0);

    issue("seq0", 32'h0123_4820, 0, 3'd0, 0, 0, 0, 0, 0, 32'h4, 0);
    issue("seq1", 32'h8C43_0010, 0, 3'd0, 0, 0, 0, 0, 0, 32'h8, 0);
    issue("j100", 32'h0800_0040, 0, 3'd0, 1, 0, 0, 0, 0, 32'h100, 0);
    issue("beq_t", 32'h1022_FFFE, 1, 3'd0, 0, 0, 5, 5, 0, 32'h0FC, 0);
    issue("nop", 32'h0000_0000, 0, 3'd0, 0, 0, 0, 0, 0, 32'h100, 0);
    issue("beq_nt", 32'h1022_FFFE, 1, 3'd0, 0, 0, 5, 6, 0, 32'h104, 0);
    issue("gtu_t", 32'h1022_0004, 1, 3'd6, 0, 0, 32'hFFFF_FFFF, 1, 0, 32'h118, 0);
    issue("gt_nt", 32'h1022_0004, 1, 3'd2, 0, 0, 32'hFFFF_FFFF, 1, 0, 32'h11C, 0);
    issue("jr_mis", 32'h0800_0040, 0, 3'd0, 1, 1, 0, 0, 32'h2003, 32'h2000, 1);
    issue("jr_top", 32'h0000_0008, 0, 3'd0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    issue("wrap4", 32'h0000_0000, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0, 0);
    issue("brwrap", 32'h1022_FFFE, 1, 3'd0, 0, 0, 7, 7, 0, 32'hFFFF_FFFC, 0);
    issue("j_wrap", 32'h0800_0040, 0, 3'd0, 1, 0, 0, 0, 0, 32'h100, 0);
    for (int i = 0; i < 6; i++) begin
      issue($sformatf("bt%0d", tbl_bt[i]), 32'h1022_0002, tbl_br[i], tbl_bt[i], 0, 0,
            tbl_a[i], tbl_b[i], 0, tbl_exp[i], 0);
    end

    // Timeout: no ready; ack and redirect outside HOLD must do nothing.
    instr_ack = 1'b1; jump_reg = 1'b1; jr_target = 32'h4000;
    for (int i = 0; i < FT - 1; i++) tick();
    chk("tmo err_before", {31'b0, fetch_err}, 32'd0);
    tick();
    chk("tmo err_set", {31'b0, fetch_err}, 32'd1);
    chk("tmo req_held", {31'b0, imem_req}, 32'd1);
    chk("tmo addr_held", imem_addr, 32'h130);
    instr_ack = 1'b0;
    clear_redirect();
    tick(); tick();
    chk("tmo err_sticky", {31'b0, fetch_err}, 32'd1);
    $display("txn timeout: fetch_err=%0b addr=%h", fetch_err, imem_addr);

    // Reset in the middle of FETCH with a response arriving.
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst err", {31'b0, fetch_err}, 32'd0);
    chk("mid_rst addr", imem_addr, RPC);
    chk("mid_rst instr", instr, 32'd0);
    imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("restart req", {31'b0, imem_req}, 32'd1);
    chk("restart addr", imem_addr, RPC);
    issue("restart", 32'h2108_0001, 0, 3'd0, 0, 0, 0, 0, 0, 32'h4, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
